// File: rtl/hls_mem_responder.sv
// Memory-side responder for HLS kernels: on-chip word storage with a fixed-latency read
// pipeline, a credit-limited FWFT response queue, and a host preload/readback port.
module hls_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0] host_rdata_q;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] q_push_data;

    logic              req_fire;
    logic              ld_fire;
    logic              st_fire;
    logic              q_push;
    logic              q_pop;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W:0]    credits_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both loads still in the pipe and words already queued, so the queue never overflows.
    assign credits_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign req_ready    = !host_we && (req_we || (credits_used < (CNT_W+1)'(FIFO_DEPTH)));
    assign req_fire     = req_valid && req_ready;
    assign ld_fire      = req_fire && !req_we;
    assign st_fire      = req_fire && req_we;
    assign rd_word      = mem_q[req_addr];

    generate
        if (RD_LAT == 1) begin : g_direct
            assign q_push      = ld_fire;
            assign q_push_data = rd_word;
        end else begin : g_pipe
            logic              vld_q  [RD_LAT-1];
            logic [DATA_W-1:0] data_q [RD_LAT-1];

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    for (int i = 0; i < RD_LAT-1; i++) vld_q[i] <= 1'b0;
                end else begin
                    vld_q[0] <= ld_fire;
                    for (int i = 1; i < RD_LAT-1; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            always_ff @(posedge sys_clk) begin
                data_q[0] <= rd_word;
                for (int i = 1; i < RD_LAT-1; i++) data_q[i] <= data_q[i-1];
            end

            assign q_push      = vld_q[RD_LAT-2];
            assign q_push_data = data_q[RD_LAT-2];
        end
    endgenerate

    assign q_pop = (count_q != '0) && resp_ready;

    always_comb begin
        wr_ptr_d   = q_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = q_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CNT_W'(q_push) - CNT_W'(q_pop);
        inflight_d = inflight_q + CNT_W'(ld_fire) - CNT_W'(q_push);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            host_rdata_q <= mem_q[host_addr];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (q_push) fifo_q[wr_ptr_q] <= q_push_data;
    end

    // Storage survives reset so host preloads remain valid across a kernel restart.
    always_ff @(posedge sys_clk) begin
        if (host_we)      mem_q[host_addr] <= host_wdata;
        else if (st_fire) mem_q[req_addr]  <= req_wdata;
    end

    assign resp_valid = (count_q != '0);
    assign resp_data  = fifo_q[rd_ptr_q];
    assign host_rdata = host_rdata_q;
    assign busy       = (inflight_q != '0) || (count_q != '0);

endmodule
